// File: rtl/pd_pkg.sv
// Shared types and constants for the multi-pattern serial detector.
// Slot configuration is carried at full 32-bit width; each instance uses the low MAX_LEN bits.
package pd_pkg;

    localparam int PD_MAX_LEN_DEF = 8;
    localparam int PD_NUM_PAT_DEF = 4;
    localparam int PD_CNT_W_DEF   = 8;

    localparam int PD_MAX_W = 32;
    localparam int PD_LEN_W = 6;

    // Index and length fields: $clog2(n), but never narrower than one bit.
    function automatic int pd_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [PD_MAX_W-1:0] pattern;
        logic [PD_MAX_W-1:0] mask;
        logic [PD_LEN_W-1:0] len;
    } pd_slot_cfg_t;

endpackage

// File: rtl/pattern_detector_multi_slot.sv
// One pattern slot: configuration registers plus the masked compare and eligibility check.
// The hit output is combinational; the top gates it with in_valid and registers it.
module pd_slot
    import pd_pkg::*;
#(
    parameter int MAX_LEN = PD_MAX_LEN_DEF,
    parameter int LEN_W   = pd_width(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_we,
    input  pd_slot_cfg_t       i_cfg,
    input  logic [MAX_LEN-1:0] i_hist_next,
    input  logic [LEN_W-1:0]   i_fill_next,
    output logic               o_hit
);

    pd_slot_cfg_t        r_cfg;
    logic [PD_MAX_W-1:0] w_hist;
    logic [PD_LEN_W-1:0] w_fill;
    logic                w_eq;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_cfg.pattern <= '0;
            r_cfg.mask    <= '1;
            r_cfg.len     <= '0;
        end else if (i_we) begin
            r_cfg <= i_cfg;
        end
    end

    // Only bit positions below len take part; mask bits above it are ignored.
    always_comb begin
        w_hist = '0;
        w_hist[MAX_LEN-1:0] = i_hist_next;
        w_fill = '0;
        w_fill[LEN_W-1:0] = i_fill_next;
        w_eq = 1'b1;
        for (int i = 0; i < PD_MAX_W; i++) begin
            if ((PD_LEN_W'(i) < r_cfg.len) && r_cfg.mask[i] && (w_hist[i] != r_cfg.pattern[i]))
                w_eq = 1'b0;
        end
        o_hit = (r_cfg.len != '0) && (w_fill >= r_cfg.len) && w_eq;
    end

endmodule

// File: rtl/pattern_detector_multi.sv
// Serial detector matching one bit stream against NUM_PAT programmable, masked patterns.
// Optional match counter (ports count_clr, match_count) is built when PD_MATCH_COUNT_EN is defined.
module pattern_detector_multi
    import pd_pkg::*;
#(
    parameter int  MAX_LEN = PD_MAX_LEN_DEF,
    parameter int  NUM_PAT = PD_NUM_PAT_DEF,
    parameter int  CNT_W   = PD_CNT_W_DEF,
    localparam int IDX_W   = pd_width(NUM_PAT),
    localparam int LEN_W   = pd_width(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [MAX_LEN-1:0] cfg_mask,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic [NUM_PAT-1:0] match_vec,
    output logic               z
`ifdef PD_MATCH_COUNT_EN
    ,
    input  logic               count_clr,
    output logic [CNT_W-1:0]   match_count
`endif
);

    if (MAX_LEN < 2 || MAX_LEN > 32 || NUM_PAT < 1 || NUM_PAT > 16 || CNT_W < 1) begin : g_bad_params
        $error("pattern_detector_multi: parameter out of range");
    end

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_next;
    logic [NUM_PAT-1:0] w_hit;
    logic [NUM_PAT-1:0] w_match_next;
    logic [NUM_PAT-1:0] r_match;
    logic               r_z;
    pd_slot_cfg_t       w_cfg;

    always_comb begin
        w_hist_next  = {r_hist[MAX_LEN-2:0], in_bit};
        w_fill_next  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
        w_match_next = in_valid ? w_hit : '0;

        w_cfg = '0;
        w_cfg.pattern[MAX_LEN-1:0] = cfg_pattern;
        w_cfg.mask[MAX_LEN-1:0]    = cfg_mask;
        w_cfg.len[LEN_W-1:0]       = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    end

    // Out-of-range indices decode to no slot, so such writes fall away naturally.
    for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
        pd_slot #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_slot (
            .clk         (clk),
            .i_reset     (reset),
            .i_we        (cfg_we && (cfg_idx == IDX_W'(k))),
            .i_cfg       (w_cfg),
            .i_hist_next (w_hist_next),
            .i_fill_next (w_fill_next),
            .o_hit       (w_hit[k])
        );
    end

    // Non-overlapping mode restarts the fill count so every next match needs fresh bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= '0;
            r_z     <= 1'b0;
        end else begin
            r_match <= w_match_next;
            r_z     <= |w_match_next;
            if (in_valid) begin
                r_hist <= w_hist_next;
                r_fill <= (!overlap && (|w_hit)) ? '0 : w_fill_next;
            end
        end
    end

    assign match_vec = r_match;
    assign z         = r_z;

`ifdef PD_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (count_clr) begin
            r_cnt <= '0;
        end else if ((|w_match_next) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_count = r_cnt;
`endif

endmodule
